// File: rtl/sevenseg_mux_pwm_if.sv
// Host-side bundle for the multiplexed seven-segment driver:
// display data, load strobe and brightness in, segment/anode pins and frame out.
interface sevenseg_mux_pwm_if #(
  parameter int DIGITS = 4,
  parameter int PWM_W  = 4
);
  logic [4*DIGITS-1:0] digit_data;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic [PWM_W-1:0]    brightness;
  logic                load;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   an_n;
  logic                frame;

  modport master (
    output digit_data, dp_in, blank_in, brightness, load,
    input  seg_n, dp_n, an_n, frame
  );

  modport slave (
    input  digit_data, dp_in, blank_in, brightness, load,
    output seg_n, dp_n, an_n, frame
  );
endinterface

// File: rtl/sevenseg_mux_pwm.sv
// Multiplexed common-anode hex display driver with PWM dimming and double-buffered data.
// Optional SEVENSEG_LEADING_ZERO_BLANK_EN suppresses leading zeros (digit 0 always shown).
module sevenseg_mux_pwm #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 18,
  parameter int PWM_W  = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  sevenseg_mux_pwm_if.slave  bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*DIGITS-1:0] act_data_q, act_data_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                boundary;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [PWM_W-1:0]    phase;
  logic                lit;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    boundary = (cnt_q == '0) && (idx_q == '0);
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_q == '1) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    pend_data_d  = bus.load ? bus.digit_data : pend_data_q;
    pend_dp_d    = bus.load ? bus.dp_in      : pend_dp_q;
    pend_blank_d = bus.load ? bus.blank_in   : pend_blank_q;

    // Swapping at the boundary through pend_*_d lets a coincident load go straight to display.
    act_data_d  = boundary ? pend_data_d  : act_data_q;
    act_dp_d    = boundary ? pend_dp_d    : act_dp_q;
    act_blank_d = boundary ? pend_blank_d : act_blank_q;
  end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  always_comb begin : lz_scan
    logic run;
    lz_blank = '0;
    run      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && (act_data_d[4*i +: 4] == 4'h0) && !act_dp_d[i]) begin
        lz_blank[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = act_data_d[4*i +: 4];
        cur_dp    = act_dp_d[i];
        cur_blank = act_blank_d[i] | lz_blank[i];
      end
    end

    phase = cnt_q[DIV_W-1 -: PWM_W];
    lit   = (phase < bus.brightness) && !cur_blank;

    seg_d   = lit ? decode(cur_nib) : 7'h7F;
    dp_d    = lit ? ~cur_dp : 1'b1;
    an_d    = lit ? ~(DIGITS'(1) << idx_q) : '1;
    frame_d = boundary;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;
  assign bus.an_n  = an_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_sevenseg_mux_pwm.sv
// Directed bench for sevenseg_mux_pwm with DIGITS=4, DIV_W=4, PWM_W=2 (64-cycle frames).
module tb_sevenseg_mux_pwm;
  localparam int DIGITS = 4;
  localparam int DIV_W  = 4;
  localparam int PWM_W  = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [12:0] RST_VEC = {1'b0, 4'hF, 7'h7F, 1'b1};

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   passes  = 0;

  always #5 clock = ~clock;

  sevenseg_mux_pwm_if #(.DIGITS(DIGITS), .PWM_W(PWM_W)) bus ();

  sevenseg_mux_pwm #(.DIGITS(DIGITS), .DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Expected {frame, an_n, seg_n, dp_n} k cycles after a frame pulse; segs packed {d3,d2,d1,d0}.
  function automatic logic [12:0] exp_vec(input int k, input logic [27:0] segs,
                                          input logic [3:0] dps, input logic [3:0] dark,
                                          input logic [1:0] br);
    int d;
    int c;
    logic [12:0] v;
    d = (k / 16) % 4;
    c = k % 16;
    v = {(k % 64) == 0, 4'hF, 7'h7F, 1'b1};
    if ((c / 4) < int'(br) && !dark[d]) begin
      v[11:8] = ~(4'b0001 << d);
      v[7:1]  = segs[7*d +: 7];
      v[0]    = ~dps[d];
    end
    return v;
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus.frame, bus.an_n, bus.seg_n, bus.dp_n};
  endfunction

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.frame === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.digit_data = d;
    bus.dp_in      = dp;
    bus.blank_in   = bl;
    bus.load       = 1'b1;
    @(negedge clock);
    bus.load       = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (obs_vec() !== RST_VEC) $display("FAIL reset_hold k=%0d got %h expected %h", k, obs_vec(), RST_VEC);
      else passes++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 130; k++) begin
      @(negedge clock);
      e = {(k % 64) == 0, 4'hF, 7'h7F, 1'b1};
      checks++;
      if (obs_vec() !== e) $display("FAIL reset_frame k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
  endtask

  task automatic test_scan();
    bit ok;
    logic [12:0] e;
    bus.brightness = 2'd3;
    do_load(16'h3A0F, 4'b0100, 4'b0000);
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL scan_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, {S3, SA, S0, SF}, 4'b0100, 4'b0000, 2'd3);
      checks++;
      if (obs_vec() !== e) $display("FAIL scan k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    logic [12:0] e;
    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL tear_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 128; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, (k < 64) ? {S1, S1, S1, S1} : {S2, S2, S2, S2}, 4'b0000, 4'b0000, 2'd3);
      checks++;
      if (obs_vec() !== e) $display("FAIL tear_free k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
      if (k == 40) begin
        bus.digit_data = 16'h2222;
        bus.load       = 1'b1;
      end
      if (k == 41) bus.load = 1'b0;
    end
  endtask

  task automatic test_load_boundary();
    bit ok;
    logic [12:0] e;
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL boundary_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 128; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, (k < 64) ? {S2, S2, S2, S2} : {S4, S4, S4, S4}, 4'b0000, 4'b0000, 2'd3);
      checks++;
      if (obs_vec() !== e) $display("FAIL load_boundary k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
      if (k == 63) begin
        bus.digit_data = 16'h4444;
        bus.load       = 1'b1;
      end
      if (k == 64) bus.load = 1'b0;
    end
  endtask

  task automatic test_blank_brightness();
    bit ok;
    logic [12:0] e;
    bus.brightness = 2'd0;
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL dark_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, {S4, S4, S4, S4}, 4'b0000, 4'b0000, 2'd0);
      checks++;
      if (obs_vec() !== e) $display("FAIL bright0 k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
    bus.brightness = 2'd2;
    do_load(16'h3A0F, 4'b0100, 4'b0010);
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL blank_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, {S3, SA, S0, SF}, 4'b0100, 4'b0010, 2'd2);
      checks++;
      if (obs_vec() !== e) $display("FAIL blank1 k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
  endtask

  task automatic test_lead_zero();
    bit ok;
    logic [12:0] e;
    logic [3:0] dark_a;
    logic [3:0] dark_b;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    dark_a = 4'b1100;
    dark_b = 4'b1110;
`else
    dark_a = 4'b0000;
    dark_b = 4'b0000;
`endif
    bus.brightness = 2'd3;
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL lz_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, {S0, S0, S5, S0}, 4'b0000, dark_a, 2'd3);
      checks++;
      if (obs_vec() !== e) $display("FAIL lz_0050 k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL lz0_frame_timeout got 0 expected 1");
    else passes++;
    for (int k = 0; k < 64; k++) begin
      if (k != 0) @(negedge clock);
      e = exp_vec(k, {S0, S0, S0, S0}, 4'b0000, dark_b, 2'd3);
      checks++;
      if (obs_vec() !== e) $display("FAIL lz_0000 k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [12:0] e;
    wait_frame(ok);
    checks++;
    if (!ok) $display("FAIL areset_frame_timeout got 0 expected 1");
    else passes++;
    @(negedge clock);
    @(negedge clock);
    e = {1'b0, 4'b1110, S0, 1'b1};
    checks++;
    if (obs_vec() !== e) $display("FAIL areset_before got %h expected %h", obs_vec(), e);
    else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== RST_VEC) $display("FAIL areset_immediate got %h expected %h", obs_vec(), RST_VEC);
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      e = {k == 0, 4'hF, 7'h7F, 1'b1};
      checks++;
      if (obs_vec() !== e) $display("FAIL areset_after k=%0d got %h expected %h", k, obs_vec(), e);
      else passes++;
    end
  endtask

  initial begin
    bus.digit_data = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.brightness = '0;
    bus.load       = 1'b0;
    test_reset();
    test_scan();
    test_tear_free();
    test_load_boundary();
    test_blank_brightness();
    test_lead_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
